brick_rand_loader: RTL and testbench
====================================

// Module: brick_rand_loader
// PURPOSE
//  Upstream feeder for the brick matrix block. On a start pulse it generates a
//  pseudo-random 16x16 brick layout and streams it one entry at a time on
//  random/randomColor/randomIndex. The matrix block writes each entry and
//  counts the non-transparent bricks. An LFSR picks each colour from a fixed
//  palette. Only the top FILL_ROWS rows receive bricks.
// PARAMETERS
//  LFSR_SEED     16'hACE1  non-zero LFSR reset value
//  FILL_ROWS     8         rows 0..FILL_ROWS-1 random; rows below forced 8'hFF
//  EMPTY_THRESH  4         out of 16: lfsr[7:4] < EMPTY_THRESH -> transparent entry
//  NUM_ENTRIES   255       entries streamed, index 0..NUM_ENTRIES-1
//                          (matrix block ignores index 255)
// PORTS
//  clk          in   1   system clock
//  resetN       in   1   reset, asynchronous, active-low
//  start        in   1   level sampled; starts a load when in IDLE
//  random       out  1   entry strobe, high for the first cycle of each slot
//  randomColor  out  8   entry colour, stable for the whole slot
//  randomIndex  out  8   entry index, stable for the whole slot; parks at 8'd255
//  busy         out  1   high while a load is in progress
//  done         out  1   single-cycle pulse when the last slot completes
//  brickCount   out  9   non-FF entries emitted in the current/last load
// BEHAVIOUR
//  Reset values
//   random=0, randomColor=8'hFF, randomIndex=8'd255, busy=0, done=0,
//   brickCount=0, lfsr=LFSR_SEED, state=IDLE.
//  LFSR
//   16-bit Galois, mask 16'hB400. Shifts every clk in every state
//   (free-running, so the layout depends on start time).
//   If it ever reads 0, it reloads LFSR_SEED.
//  Colour selection (lfsr value at the slot's first edge)
//   row = idx[7:4]. If row >= FILL_ROWS or lfsr[7:4] < EMPTY_THRESH -> 8'hFF.
//   Otherwise palette[lfsr[1:0]] = {0:8'h6D, 1:8'hFC, 2:8'hE0, 3:8'h1F}.
//  Slot timing
//   Each entry occupies a 2-cycle slot: STROBE (random=1) then HOLD (random=0).
//   Index and colour are constant across both cycles, because the consumer
//   samples random one cycle late. Every entry is therefore written exactly once.
//  FSM
//   IDLE -(start)-> STROBE -> HOLD -> (idx < NUM_ENTRIES-1 ? STROBE,idx+1 : FIN)
//   FIN -> IDLE.
//   - The edge taking start in IDLE clears brickCount, sets busy.
//     At t+1 the outputs are random=1, randomIndex=0.
//   - Strobe for index k is at cycle t+1+2k.
//   - Last HOLD is at t+2*NUM_ENTRIES.
//   - FIN cycle t+2*NUM_ENTRIES+1: done=1, busy=0, randomIndex=8'd255,
//     randomColor=8'hFF, random=0.
//   - brickCount increments in the STROBE cycle of each non-FF entry.
//     It saturates at 9'd256 and holds after done until the next start.
//  Boundaries
//   - start while busy or in FIN: ignored, no restart.
//   - start held high continuously: a new load begins one cycle after FIN.
//   - resetN low mid-load: immediate return to reset values. Any partial
//     layout already written stays in the consumer; no cleanup is performed.
//   - FILL_ROWS=0: all entries FF, brickCount=0.
//   - FILL_ROWS>=16 is treated as 16.
//   - randomIndex is never 255 while random=1.
// TESTING
//  1 Reset asserted mid-operation -> all outputs equal reset values within the
//    same cycle (asynchronous).
//  2 start pulse at t=10 -> random=1/idx=0 at 11; idx=254 strobe at 519;
//    busy high 11..520; done=1 and busy=0 at 521; idx=255 after.
//  3 EMPTY_THRESH=0, FILL_ROWS=8 -> idx 0..127 non-FF, idx 128..254 FF,
//    brickCount=128; consumer numBricks equals 128.
//  4 EMPTY_THRESH=16 -> every randomColor=8'hFF, brickCount=0.
//  5 start re-pulsed at cycle 100 of a load -> no restart, done still at
//    cycle t+511.
//  6 Same start cycle after two resets -> identical colour sequence; check
//    strobes are one per slot, with index/colour stable across HOLD.

Source files
------------

// File: rtl/brick_rand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : brick_rand_loader
//  Description : Streams a pseudo-random 16x16 brick layout to the brick
//                matrix block, one entry per two-cycle slot. Colours come from
//                a free-running 16-bit Galois LFSR and a fixed four-colour
//                palette. Only the top FILL_ROWS rows can receive bricks.
//  Revision    : 1.0  initial release
// ============================================================================
module brick_rand_loader #(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          FILL_ROWS    = 8,
    parameter int          EMPTY_THRESH = 4,
    parameter int          NUM_ENTRIES  = 255
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    output logic       random,
    output logic [7:0] randomColor,
    output logic [7:0] randomIndex,
    output logic       busy,
    output logic       done,
    output logic [8:0] brickCount
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_STROBE = 2'd1;
    localparam logic [1:0]  S_HOLD   = 2'd2;
    localparam logic [1:0]  S_FIN    = 2'd3;

    // Rows are only 4 bits wide, so anything past 16 behaves like 16.
    localparam int          FILL_EFF    = (FILL_ROWS > 16) ? 16 :
                                          ((FILL_ROWS < 0) ? 0 : FILL_ROWS);
    localparam logic [7:0]  LAST_IDX    = 8'(NUM_ENTRIES - 1);
    localparam logic [15:0] LFSR_MASK   = 16'hB400;
    localparam logic [7:0]  COLOR_EMPTY = 8'hFF;
    localparam logic [7:0]  IDX_PARK    = 8'd255;
    localparam logic [8:0]  COUNT_MAX   = 9'd256;

    logic [1:0]  state_q, state_d;
    logic [15:0] lfsr_q,  lfsr_d;
    logic [7:0]  idx_q,   idx_d;
    logic [7:0]  color_q, color_d;
    logic [8:0]  count_q, count_d;

    logic [7:0]  next_idx;
    logic [3:0]  pick_row;
    logic [7:0]  pick_color;
    logic        enter_strobe;

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> STROBE <-> HOLD -> FIN -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_STROBE;
            S_STROBE: state_d = S_HOLD;
            S_HOLD:   state_d = (idx_q < LAST_IDX) ? S_STROBE : S_FIN;
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Control outputs decoded straight from the current state.
    always_comb begin
        random = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            S_STROBE: begin
                random = 1'b1;
                busy   = 1'b1;
            end
            S_HOLD:   busy = 1'b1;
            S_FIN:    done = 1'b1;
            default:  ;
        endcase
    end

    // Datapath registers: LFSR, slot index/colour and brick counter.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lfsr_q  <= LFSR_SEED;
            idx_q   <= IDX_PARK;
            color_q <= COLOR_EMPTY;
            count_q <= 9'd0;
        end else begin
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            color_q <= color_d;
            count_q <= count_d;
        end
    end

    // Free-running Galois LFSR; a zero state would lock up, so reseed.
    always_comb begin
        if (lfsr_q == 16'd0) begin
            lfsr_d = LFSR_SEED;
        end else if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ LFSR_MASK;
        end else begin
            lfsr_d = lfsr_q >> 1;
        end
    end

    // Colour for the slot about to start, from the LFSR value at its first edge.
    always_comb begin
        next_idx     = (state_q == S_IDLE) ? 8'd0 : (idx_q + 8'd1);
        pick_row     = next_idx[7:4];
        enter_strobe = (state_d == S_STROBE) && (state_q != S_STROBE);
        if ((int'(pick_row) >= FILL_EFF) || (int'(lfsr_q[7:4]) < EMPTY_THRESH)) begin
            pick_color = COLOR_EMPTY;
        end else begin
            case (lfsr_q[1:0])
                2'd0:    pick_color = 8'h6D;
                2'd1:    pick_color = 8'hFC;
                2'd2:    pick_color = 8'hE0;
                default: pick_color = 8'h1F;
            endcase
        end
    end

    // Index/colour load at each slot start, park on FIN; count bricks during STROBE.
    always_comb begin
        idx_d   = idx_q;
        color_d = color_q;
        count_d = count_q;
        if ((state_q == S_IDLE) && start) begin
            count_d = 9'd0;
        end
        if (enter_strobe) begin
            idx_d   = next_idx;
            color_d = pick_color;
        end
        if ((state_q == S_STROBE) && (color_q != COLOR_EMPTY) && (count_q != COUNT_MAX)) begin
            count_d = count_q + 9'd1;
        end
        if ((state_d == S_FIN) && (state_q != S_FIN)) begin
            idx_d   = IDX_PARK;
            color_d = COLOR_EMPTY;
        end
    end

    assign randomIndex = idx_q;
    assign randomColor = color_q;
    assign brickCount  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_brick_rand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brick_rand_loader
//  Description : Self-checking bench for brick_rand_loader. A reference model
//                predicts each layout from the LFSR sequence and slot rules;
//                four instances cover default, all-brick, all-empty and
//                zero-fill-row configurations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_brick_rand_loader;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          NENT = 255;

    logic clk;
    logic resetN;
    logic start;

    logic       rnd_m, rnd_f, rnd_e, rnd_z;
    logic [7:0] col_m, col_f, col_e, col_z;
    logic [7:0] idx_m, idx_f, idx_e, idx_z;
    logic       busy_m, busy_f, busy_e, busy_z;
    logic       done_m, done_f, done_e, done_z;
    logic [8:0] cnt_m, cnt_f, cnt_e, cnt_z;

    int n_checks;
    int n_pass;

    logic [15:0] lfsr_m;
    logic        cons_rnd_d;
    logic [7:0]  cons_mem [0:255];

    brick_rand_loader u_dut (
        .clk(clk), .resetN(resetN), .start(start), .random(rnd_m),
        .randomColor(col_m), .randomIndex(idx_m), .busy(busy_m),
        .done(done_m), .brickCount(cnt_m)
    );

    brick_rand_loader #(.EMPTY_THRESH(0)) u_full (
        .clk(clk), .resetN(resetN), .start(start), .random(rnd_f),
        .randomColor(col_f), .randomIndex(idx_f), .busy(busy_f),
        .done(done_f), .brickCount(cnt_f)
    );

    brick_rand_loader #(.EMPTY_THRESH(16)) u_empty (
        .clk(clk), .resetN(resetN), .start(start), .random(rnd_e),
        .randomColor(col_e), .randomIndex(idx_e), .busy(busy_e),
        .done(done_e), .brickCount(cnt_e)
    );

    brick_rand_loader #(.FILL_ROWS(0)) u_f0 (
        .clk(clk), .resetN(resetN), .start(start), .random(rnd_z),
        .randomColor(col_z), .randomIndex(idx_z), .busy(busy_z),
        .done(done_z), .brickCount(cnt_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference LFSR sequence: plain Galois step, reseed on zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v == 16'd0) return SEED;
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Colour rule for entry k given the LFSR value at its slot start.
    function automatic logic [7:0] entry_colour(input logic [15:0] v, input int k,
                                                input int fill, input int thr);
        int f;
        f = (fill > 16) ? 16 : fill;
        if ((k / 16) >= f || int'(v[7:4]) < thr) return 8'hFF;
        case (v[1:0])
            2'd0:    return 8'h6D;
            2'd1:    return 8'hFC;
            2'd2:    return 8'hE0;
            default: return 8'h1F;
        endcase
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) lfsr_m <= SEED;
        else         lfsr_m <= lfsr_step(lfsr_m);
    end

    // Consumer stand-in for the all-brick instance: samples random one cycle late.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cons_rnd_d <= 1'b0;
        end else begin
            cons_rnd_d <= rnd_f;
            if (cons_rnd_d && idx_f != 8'd255) cons_mem[idx_f] <= col_f;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".random"}, rnd_m, 0);
        check({tag, ".colour"}, col_m, 8'hFF);
        check({tag, ".index"},  idx_m, 8'd255);
        check({tag, ".busy"},   busy_m, 0);
        check({tag, ".done"},   done_m, 0);
        check({tag, ".count"},  cnt_m, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_hold");
        resetN = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One full load; entry k strobes at cycle 1+2k after the start edge, FIN at 511.
    task automatic run_load(input int repulse_at, input bit hold);
        logic [15:0] v;
        logic [7:0]  e_m [0:254];
        logic [7:0]  e_f [0:254];
        logic [7:0]  e_e [0:254];
        logic [7:0]  e_z [0:254];
        int bm, bf, be, bz, k, ph, cons_cnt;
        @(negedge clk);
        start = 1'b1;
        v = lfsr_m;
        bm = 0; bf = 0; be = 0; bz = 0;
        for (int j = 0; j < NENT; j++) begin
            e_m[j] = entry_colour(v, j, 8, 4);
            e_f[j] = entry_colour(v, j, 8, 0);
            e_e[j] = entry_colour(v, j, 8, 16);
            e_z[j] = entry_colour(v, j, 0, 4);
            if (e_m[j] != 8'hFF) bm++;
            if (e_f[j] != 8'hFF) bf++;
            if (e_e[j] != 8'hFF) be++;
            if (e_z[j] != 8'hFF) bz++;
            v = lfsr_step(lfsr_step(v));
        end
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 512; c++) begin
            if (c <= 2 * NENT) begin
                k  = (c - 1) / 2;
                ph = (c - 1) % 2;
                check("slot.random", rnd_m, (ph == 0));
                check("slot.index",  idx_m, k);
                check("slot.colour", col_m, e_m[k]);
                check("slot.busy",   busy_m, 1);
                check("slot.done",   done_m, 0);
                if (ph == 0) begin
                    check("full.colour",  col_f, e_f[k]);
                    check("empty.colour", col_e, e_e[k]);
                    check("fill0.colour", col_z, e_z[k]);
                end
            end else if (c == 2 * NENT + 1) begin
                check("fin.done",   done_m, 1);
                check("fin.busy",   busy_m, 0);
                check("fin.random", rnd_m, 0);
                check("fin.index",  idx_m, 8'd255);
                check("fin.colour", col_m, 8'hFF);
                check("fin.count",  cnt_m, bm);
                check("full.count", cnt_f, 128);
                check("full.model", bf, 128);
                check("empty.count", cnt_e, be);
                check("empty.zero",  cnt_e, 0);
                check("fill0.count", cnt_z, bz);
                check("full.done",   done_f, 1);
                cons_cnt = 0;
                for (int j = 0; j < NENT; j++) if (cons_mem[j] != 8'hFF) cons_cnt++;
                check("consumer.bricks", cons_cnt, 128);
            end else begin
                check("after.done",   done_m, 0);
                check("after.busy",   busy_m, 0);
                check("after.random", rnd_m, 0);
                check("after.index",  idx_m, 8'd255);
                check("after.count",  cnt_m, bm);
            end
            if (c == repulse_at)     start = 1'b1;
            if (c == repulse_at + 1) start = 1'b0;
            @(negedge clk);
        end
        if (hold) begin
            check("restart.random", rnd_m, 1);
            check("restart.index",  idx_m, 0);
            check("restart.busy",   busy_m, 1);
            start = 1'b0;
        end
    endtask

    initial begin
        int w;
        n_checks = 0;
        n_pass   = 0;
        start    = 1'b0;
        resetN   = 1'b0;
        for (int j = 0; j < 256; j++) cons_mem[j] = 8'hFF;
        do_reset();

        // Asynchronous reset in the middle of a load.
        idle_cycles($urandom_range(2, 20));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle_cycles($urandom_range(30, 200));
        check("midload.busy", busy_m, 1);
        #2 resetN = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        resetN = 1'b1;

        // Plain load after a random idle gap.
        idle_cycles($urandom_range(1, 40));
        run_load(-1, 1'b0);

        // Start re-pulsed mid-load must not restart the sequence.
        idle_cycles($urandom_range(1, 40));
        run_load(100, 1'b0);
        idle_cycles($urandom_range(1, 30));
        run_load($urandom_range(2, 500), 1'b0);

        // Same start cycle after two resets reproduces the same layout.
        w = $urandom_range(3, 40);
        do_reset();
        idle_cycles(w);
        run_load(-1, 1'b0);
        do_reset();
        idle_cycles(w);
        run_load(-1, 1'b0);

        // Start held high: next load strobes two cycles after FIN.
        idle_cycles($urandom_range(1, 10));
        run_load(-1, 1'b1);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
